// File: rtl/ctrl_fsm_if.sv
// Instruction-memory fetch channel between the controller (master) and
// the instruction memory (slave).
interface ctrl_fsm_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute controller for the 8-bit ALU datapath: owns PC, IR,
// the immediate byte and the condition-code register.
module ctrl_fsm #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [7:0] MAX_WAIT = 8'd255
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_fsm_if.master       imem,
    output logic [3:0]       alu_op,
    output logic [1:0]       ra_field,
    output logic             dec_ra,
    output logic             c_in,
    output logic             old_z,
    output logic             old_n,
    output logic             old_c,
    output logic             old_v,
    output logic [1:0]       rf_a_addr,
    output logic [1:0]       rf_b_addr,
    input  logic [7:0]       rf_b_data,
    input  logic [7:0]       alu_result,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_flags_update,
    output logic             rf_we,
    output logic [1:0]       rf_waddr,
    output logic [7:0]       rf_wdata,
    output logic             halted,
    output logic             fault
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH2,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_SETCLR = 4'd6;
    localparam logic [3:0] OP_DEC    = 4'd8;
    localparam logic [3:0] OP_JMP    = 4'd9;
    localparam logic [3:0] OP_LOOP   = 4'd10;
    localparam logic [3:0] OP_LDM    = 4'd12;
    localparam logic [3:0] OP_HLT    = 4'd15;

    state_t     state, state_d;
    logic [7:0] pc, pc_d;
    logic [7:0] ir, ir_d;
    logic [7:0] imm, imm_d;
    logic [3:0] ccr, ccr_d;          // {Z, N, C, V}
    logic [7:0] wait_cnt, wait_d;
    logic       fault_q, fault_d;
    logic       req_en;              // keeps imem_req low for the first cycle out of reset

    logic [3:0] opcode;
    logic [1:0] ra;
    logic       cond_flag;

    assign opcode = ir[7:4];
    assign ra     = ir[3:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            pc       <= PC_RESET;
            ir       <= '0;
            imm      <= '0;
            ccr      <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            req_en   <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            imm      <= imm_d;
            ccr      <= ccr_d;
            wait_cnt <= wait_d;
            fault_q  <= fault_d;
            req_en   <= 1'b1;
        end
    end

    always_comb begin
        cond_flag = 1'b0;
        case (ra)
            2'd0: cond_flag = ccr[3];
            2'd1: cond_flag = ccr[2];
            2'd2: cond_flag = ccr[1];
            2'd3: cond_flag = ccr[0];
            default: cond_flag = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        ir_d          = ir;
        imm_d         = imm;
        ccr_d         = ccr;
        wait_d        = wait_cnt;
        fault_d       = fault_q;
        imem.imem_req = 1'b0;
        alu_op        = '0;
        dec_ra        = 1'b0;
        rf_we         = 1'b0;
        rf_wdata      = alu_result;
        halted        = 1'b0;

        case (state)
            ST_FETCH, ST_FETCH2: begin
                imem.imem_req = req_en;
                if (req_en) begin
                    if (imem.imem_ack) begin
                        if (state == ST_FETCH) begin
                            ir_d    = imem.imem_rdata;
                            state_d = ST_DECODE;
                        end else begin
                            imm_d   = imem.imem_rdata;
                            state_d = ST_EXEC;
                        end
                        pc_d   = pc + 8'd1;
                        wait_d = '0;
                    end else if (wait_cnt == MAX_WAIT) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_cnt + 8'd1;
                    end
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OP_LDM, OP_LOOP: state_d = ST_FETCH2;
                    OP_HLT:          state_d = ST_HALT;
                    default:         state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                if (alu_flags_update) begin
                    ccr_d = {alu_z, alu_n, alu_c, alu_v};
                end
                case (opcode)
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, OP_DEC: begin
                        alu_op = opcode;
                        rf_we  = 1'b1;
                    end
                    OP_SETCLR: begin
                        // ra of 2/3 selects SETC/CLRC, which only touch flags
                        alu_op = opcode;
                        rf_we  = ~ra[1];
                    end
                    OP_LOOP: begin
                        alu_op = OP_DEC;
                        dec_ra = 1'b1;
                        rf_we  = 1'b1;
                        if (!alu_z) begin
                            pc_d = imm;
                        end
                    end
                    OP_JMP: begin
                        if (cond_flag) begin
                            pc_d = rf_b_data;
                        end
                    end
                    OP_LDM: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end
                    default: ;
                endcase
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: state_d = ST_HALT;
        endcase
    end

    assign imem.imem_addr = pc;
    assign ra_field       = ra;
    assign rf_a_addr      = ra;
    assign rf_b_addr      = ir[1:0];
    assign rf_waddr       = ra;
    assign c_in           = ccr[1];
    assign old_z          = ccr[3];
    assign old_n          = ccr[2];
    assign old_c          = ccr[1];
    assign old_v          = ccr[0];
    assign fault          = fault_q;

endmodule
